coeff_lut_ram: RTL and testbench

- Single-port synchronous block RAM holding the piecewise-linear coefficient tables for the log-approximation datapath.
- Two instances are used. One holds the slope table "a"; the other holds the intercept table "b".
- Both instances are addressed by the segment-select encoder with a 3-bit segment address. The datapath computes out = a*x + b from the two read words.
- Behaviour is equivalent to a vendor single-port BRAM: native port names, write-first mode, one-cycle read latency. An asynchronous active-low output reset is added.

---
 rtl/coeff_lut_ram.sv | 81 ++++++++
 tb/tb_coeff_lut_ram.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/coeff_lut_ram.sv
// -----------------------------------------------------------------------------
// coeff_lut_ram
//
// Single-port synchronous coefficient RAM for the piecewise-linear log
// approximation datapath. One instance holds the slope table "a". A second
// instance holds the intercept table "b". Both are addressed by the
// segment-select encoder.
//
// The port behaves like a vendor single-port block RAM:
//   - write-first mode
//   - one-cycle registered read latency
//   - an added asynchronous active-low reset that clears only the output
//     register and never the stored words
//
// Parameters:
//   DATA_W   - word width of dina / douta
//   ADDR_W   - address width
//   DEPTH    - number of words (2**ADDR_W)
//   INIT_VEC - power-up contents; word i is INIT_VEC[i*DATA_W +: DATA_W]
//
// Ports:
//   clka   - clock; all state changes on the rising edge
//   rsta_n - asynchronous active-low reset. Forces douta to 0 and blocks
//            access while low.
//   ena    - port enable; gates both read and write
//   wea    - write enable; qualified by ena
//   addra  - word address
//   dina   - write data
//   douta  - registered read data. In write-first mode it returns dina
//            on a write.
// -----------------------------------------------------------------------------
module coeff_lut_ram #(
    parameter int                         DATA_W   = 32,
    parameter int                         ADDR_W   = 3,
    parameter int                         DEPTH    = 2 ** ADDR_W,
    parameter logic [DEPTH*DATA_W-1:0]    INIT_VEC = '0
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta
);

    // Packed word array: element i lines up with INIT_VEC[i*DATA_W +: DATA_W],
    // so the power-up image loads with a plain vector assignment.
    logic [DEPTH-1:0][DATA_W-1:0] mem = INIT_VEC;
    logic [DATA_W-1:0]            douta_q = '0;

    // An access takes place only on an enabled edge outside reset.
    logic access;
    logic do_write;

    assign access   = ena && rsta_n;
    assign do_write = access && wea;

    // NOTE: the storage array has no reset branch. Clearing it would destroy
    // the coefficient tables and block RAM inference. rsta_n only qualifies
    // the write, so contents survive a reset pulse.
    always_ff @(posedge clka) begin
        if (do_write) begin
            mem[addra] <= dina;
        end
    end

    // NOTE: registered state uses non-blocking assignment. The read below
    // therefore sees the pre-edge contents of mem, and write-first data must
    // come from dina, not from the array.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            douta_q <= '0;
        end else if (ena) begin
            douta_q <= wea ? dina : mem[addra];
        end
    end

    assign douta = douta_q;

endmodule

// File: tb/tb_coeff_lut_ram.sv
// -----------------------------------------------------------------------------
// tb_coeff_lut_ram
//
// Scoreboard bench for coeff_lut_ram.
//   - The driver applies directed and random accesses on the falling edge.
//   - For each enabled access it pushes the expected douta into a queue,
//     taken from a plain array model of the RAM.
//   - The monitor samples after every rising edge:
//       * after an enabled edge it pops and compares
//       * otherwise it checks that douta held its value, or is 0 in reset
// -----------------------------------------------------------------------------
module tb_coeff_lut_ram;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    localparam logic [DEPTH*DATA_W-1:0] INIT_VEC = {
        32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
        32'h0000_1234, 32'h2222_0002, 32'h1111_0001, 32'h0BAD_F00D
    };

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    coeff_lut_ram #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .INIT_VEC(INIT_VEC)
    ) dut (
        .clka  (clk),
        .rsta_n(rst_n),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a RAM access seen as "what word comes out".
    function automatic logic [DATA_W-1:0] model_access(input logic we,
            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (we) begin
            model_mem[a] = d;
            return d;
        end
        return model_mem[a];
    endfunction

    // Drive one cycle of inputs on the falling edge.
    // An enabled access made outside reset queues its expected output.
    task automatic drive(input logic en, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        ena   = en;
        wea   = we;
        addra = a;
        dina  = d;
        if (en && rst_n) exp_q.push_back(model_access(we, a, d));
    endtask

    // Illegal-input guard: the address must be known on every enabled edge.
    always @(posedge clk) begin
        if (ena && rst_n) begin
            assert (!$isunknown(addra))
                else $error("addra is X/Z while ena=1");
        end
    end

    // Monitor / scoreboard.
    logic [DATA_W-1:0] last_out = '0;
    initial begin : monitor
        logic en_s;
        logic rst_s;
        logic [DATA_W-1:0] exp;
        forever begin
            @(posedge clk);
            en_s  = ena;
            rst_s = rst_n;
            #1;
            if (!rst_s) begin
                check("reset_hold", douta, '0);
                last_out = '0;
            end else if (en_s) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: douta %h with no expectation queued", douta);
                end else begin
                    exp = exp_q.pop_front();
                    check("access", douta, exp);
                    last_out = exp;
                end
            end else begin
                check("idle_hold", douta, last_out);
            end
        end
    end

    initial begin : driver
        logic [DEPTH*DATA_W-1:0] init_img;
        int wait_cycles;

        init_img = INIT_VEC;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_img[i*DATA_W +: DATA_W];

        // Reset: douta must read 0 with no clock edge at all.
        rst_n = 1'b0;
        ena   = 1'b0;
        wea   = 1'b0;
        addra = '0;
        dina  = '0;
        #1;
        check("reset_no_edge", douta, '0);

        // Reset also holds douta at 0 across enabled edges.
        // The monitor checks this.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 3'd3, '0);

        // Release reset. The release alone must not load douta.
        @(negedge clk);
        ena   = 1'b0;
        rst_n = 1'b1;
        #1;
        check("release_no_edge", douta, '0);

        // Init read of word 3.
        drive(1'b1, 1'b0, 3'd3, '0);

        // Write-first, then read back.
        drive(1'b1, 1'b1, 3'd5, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 3'd5, '0);

        // Enable gating: a disabled write must neither store nor update douta.
        drive(1'b1, 1'b1, 3'd2, 32'h1111_1111);
        drive(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 3'd2, '0);

        // Streaming: back-to-back writes, then back-to-back reads.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, ADDR_W'(i), 32'h100 + i);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, ADDR_W'(i), '0);

        // Reset mid-operation: contents must survive the reset.
        drive(1'b1, 1'b1, 3'd1, 32'hA5A5_A5A5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", douta, '0);
        drive(1'b1, 1'b1, 3'd1, 32'h0);   // suppressed: rst_n is low
        drive(1'b0, 1'b0, 3'd1, '0);
        @(negedge clk);
        ena   = 1'b0;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 3'd1, '0);

        // Randomized traffic, with an idle cycle now and then.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), ADDR_W'($urandom), $urandom);
        end

        // Read every word once so the final contents are compared.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, ADDR_W'(i), '0);
        drive(1'b0, 1'b0, '0, '0);

        // Drain the scoreboard, with a bounded wait.
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
